// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts one byte,
// odd parity and stop on filtered device clock falling edges and checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 8000,
    parameter int REQ_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_clk,
    input  logic       key_data,
    output logic       key_clk_drive_low,
    output logic       key_data_drive_low,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int MAX_A = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef enum logic [1:0] {IDLE, INHIBIT, REQ, SEND} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    n_q, n_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic          clk_drv_q, clk_drv_d;
    logic          data_drv_q, data_drv_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    clk_hist_q;
    logic [3:0]    data_hist_q;
    logic          fe;
    logic          ack_bit;

    // Four highs followed by four lows; data_hist_q[3] was sampled alongside the first low.
    assign fe      = (clk_hist_q == 8'b11110000);
    assign ack_bit = data_hist_q[3];

    assign tx_ready           = (state_q == IDLE) && !rst;
    assign busy               = (state_q != IDLE);
    assign key_clk_drive_low  = clk_drv_q;
    assign key_data_drive_low = data_drv_q;
    assign tx_done            = done_q;
    assign tx_error           = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            clk_drv_q   <= 1'b0;
            data_drv_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            clk_hist_q  <= 8'hFF;
            data_hist_q <= 4'hF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            shreg_q     <= shreg_d;
            parity_q    <= parity_d;
            clk_drv_q   <= clk_drv_d;
            data_drv_q  <= data_drv_d;
            done_q      <= done_d;
            err_q       <= err_d;
            clk_hist_q  <= {clk_hist_q[6:0], key_clk};
            data_hist_q <= {data_hist_q[2:0], key_data};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        clk_drv_d  = clk_drv_q;
        data_drv_d = data_drv_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shreg_d    = tx_data;
                    parity_d   = ~^tx_data;
                    n_d        = '0;
                    cnt_d      = '0;
                    clk_drv_d  = 1'b1;
                    data_drv_d = 1'b0;
                    state_d    = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d      = '0;
                    data_drv_d = 1'b1;
                    state_d    = REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REQ: begin
                if (cnt_q == CW'(REQ_CYCLES - 1)) begin
                    cnt_d     = '0;
                    clk_drv_d = 1'b0;
                    state_d   = SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (fe) begin
                    cnt_d = '0;
                    n_d   = (n_q == 4'd10) ? n_q : n_q + 4'd1;
                    if (n_q < 4'd8) begin
                        data_drv_d = ~shreg_q[n_q[2:0]];
                    end else if (n_q == 4'd8) begin
                        data_drv_d = ~parity_q;
                    end else if (n_q == 4'd9) begin
                        data_drv_d = 1'b0;
                    end else begin
                        done_d     = ~ack_bit;
                        err_d      = ack_bit;
                        clk_drv_d  = 1'b0;
                        data_drv_d = 1'b0;
                        state_d    = IDLE;
                    end
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d      = 1'b1;
                    clk_drv_d  = 1'b0;
                    data_drv_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain line model plus a behavioural PS/2 device.
module tb_ps2_host_tx;
    localparam int INH  = 200;
    localparam int REQ  = 16;
    localparam int TO   = 1000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_clk, key_data;
    logic       clk_drv, data_drv;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign key_clk  = ~(clk_drv | dev_clk_low);
    assign key_data = ~(data_drv | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .key_clk(key_clk), .key_data(key_data),
        .key_clk_drive_low(clk_drv), .key_data_drive_low(data_drv),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cyc = 0;
    int err_cyc  = 0;
    int both_cyc = 0;

    always @(negedge clk) begin
        if (tx_done) done_cyc <= done_cyc + 1;
        if (tx_error) err_cyc <= err_cyc + 1;
        if (tx_done && tx_error) both_cyc <= both_cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Issue one request and time the inhibit and request-to-send phases.
    task automatic request(input logic [7:0] d);
        int n_inh, n_req;
        @(negedge clk);
        check("ready_before_accept", int'(tx_ready), 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        n_inh = 0;
        while (clk_drv && !data_drv && n_inh < 5000) begin
            n_inh++;
            @(negedge clk);
        end
        n_req = 0;
        while (clk_drv && data_drv && n_req < 5000) begin
            n_req++;
            @(negedge clk);
        end
        check("inhibit_len", n_inh, INH);
        check("req_len", n_req, REQ);
        check("release_clk_keep_start", int'({clk_drv, data_drv}), 1);
        $display("request 0x%02h: inhibit %0d cycles, request %0d cycles", d, n_inh, n_req);
    endtask

    // Device clocks nfall falling edges; bits are sampled on rising edges (bit 9 = stop).
    task automatic dev_xfer(input int nfall, input bit ack, input bit glitch, output logic [9:0] bits);
        bits = '0;
        for (int i = 0; i < nfall; i++) begin
            if (i == 10) dev_data_low = ack;
            if (glitch && i > 0 && i < 10) begin
                repeat (12) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_clk_low = 1'b0;
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                check("ready_while_busy", int'(tx_ready), 0);
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (HALF - 16) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i < 10) bits[i] = key_data;
            dev_clk_low = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic full_xfer(input logic [7:0] d, input bit ack, input bit glitch,
                             input logic [9:0] exp_bits, input int exp_done, input int exp_err);
        logic [9:0] bits;
        int d0, e0;
        d0 = done_cyc;
        e0 = err_cyc;
        request(d);
        dev_xfer(11, ack, glitch, bits);
        repeat (2) @(negedge clk);
        check("line_bits", int'(bits), int'(exp_bits));
        check("done_pulses", done_cyc - d0, exp_done);
        check("error_pulses", err_cyc - e0, exp_err);
        check("busy_after", int'(busy), 0);
        check("lines_released", int'({clk_drv, data_drv}), 0);
        $display("xfer 0x%02h: bits 0x%03h done %0d error %0d", d, bits, done_cyc - d0, err_cyc - e0);
    endtask

    initial begin
        logic [9:0] bits;
        int k, d0, e0;

        repeat (3) @(negedge clk);
        check("rst_clk_drv", int'(clk_drv), 0);
        check("rst_data_drv", int'(data_drv), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(tx_ready), 0);
        check("rst_pulses", int'({tx_done, tx_error}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(tx_ready), 1);

        full_xfer(8'hED, 1'b1, 1'b0, 10'h3ED, 1, 0);
        full_xfer(8'hF4, 1'b1, 1'b0, 10'h2F4, 1, 0);
        full_xfer(8'h00, 1'b0, 1'b0, 10'h300, 0, 1);

        // Device never clocks.
        e0 = err_cyc;
        request(8'hF4);
        k = 0;
        while (!tx_error && k < 1500) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", k, TO);
        check("timeout_released", int'({clk_drv, data_drv}), 0);
        @(negedge clk);
        check("timeout_ready", int'(tx_ready), 1);
        check("timeout_error_pulses", err_cyc - e0, 1);
        $display("timeout: tx_error after %0d cycles", k);

        // Reset mid-transfer after four device clock edges.
        request(8'hED);
        dev_xfer(4, 1'b1, 1'b0, bits);
        d0 = done_cyc;
        e0 = err_cyc;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_released", int'({clk_drv, data_drv}), 0);
        check("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_pulses", (done_cyc - d0) + (err_cyc - e0), 0);
        check("midrst_ready", int'(tx_ready), 1);
        $display("mid-transfer reset: lines %0b%0b busy %0b", clk_drv, data_drv, busy);
        full_xfer(8'hED, 1'b1, 1'b0, 10'h3ED, 1, 0);

        // Short clock glitches and ignored requests while busy.
        full_xfer(8'hF4, 1'b1, 1'b1, 10'h2F4, 1, 0);
        repeat (5) @(negedge clk);
        check("no_spurious_start", int'(busy), 0);

        check("done_error_overlap", both_cyc, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
